// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode constants, datapath width default and sequencer state type.
package alu_pkg;
  localparam int WIDTH = 4;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_ROL = 3'b110;
  localparam logic [2:0] OP_ROR = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;
endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: instruction, ALU, result and debug signals of the sequencer.
// ALU_SEQ_ZERO_FLAG_EN adds the zero flag output.
interface alu_seq_ctrl_if #(parameter int WIDTH = alu_pkg::WIDTH, parameter int RAW = 2);
  logic             instr_valid;
  logic             instr_ready;
  logic [2:0]       instr_op;
  logic [RAW-1:0]   instr_rd;
  logic [RAW-1:0]   instr_rs;
  logic [RAW-1:0]   instr_rt;
  logic             instr_usec;
  logic             instr_ld;
  logic [WIDTH-1:0] instr_imm;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_cin;
  logic [2:0]       alu_s;
  logic [WIDTH-1:0] alu_out;
  logic             alu_co;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic [RAW-1:0]   res_rd;
  logic             carry;
  logic [RAW-1:0]   dbg_addr;
  logic [WIDTH-1:0] dbg_data;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic             zero;
`endif
  modport slave (
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output zero,
`endif
    input  instr_valid, instr_op, instr_rd, instr_rs, instr_rt, instr_usec, instr_ld, instr_imm,
    input  alu_out, alu_co, dbg_addr,
    output instr_ready, alu_a, alu_b, alu_cin, alu_s,
    output res_valid, res_data, res_rd, carry, dbg_data
  );
  modport master (
`ifdef ALU_SEQ_ZERO_FLAG_EN
    input  zero,
`endif
    output instr_valid, instr_op, instr_rd, instr_rs, instr_rt, instr_usec, instr_ld, instr_imm,
    output alu_out, alu_co, dbg_addr,
    input  instr_ready, alu_a, alu_b, alu_cin, alu_s,
    input  res_valid, res_data, res_rd, carry, dbg_data
  );
endinterface

// File: rtl/alu_seq_ctrl_regfile.sv
// alu_seq_regfile: NREGS x WIDTH register file, two operand reads, one debug read, one sync write.
module alu_seq_regfile #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  parameter int RAW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [RAW-1:0]   waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [RAW-1:0]   raddr_a_i,
  input  logic [RAW-1:0]   raddr_b_i,
  input  logic [RAW-1:0]   raddr_d_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o,
  output logic [WIDTH-1:0] rdata_d_o
);
  logic [WIDTH-1:0] mem_q [NREGS];
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];
  assign rdata_d_o = mem_q[raddr_d_i];
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: IDLE/EXEC/WB sequencer feeding an external 4-bit ALU from a register file.
// ALU_SEQ_ZERO_FLAG_EN adds a zero flag updated at write-back.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int NREGS = 4,
  parameter int RAW   = 2
) (
  input logic           clk,
  input logic           rst,
  alu_seq_ctrl_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]       s_q, s_d;
  logic             cin_q, cin_d, carry_q, carry_d;
  logic [RAW-1:0]   rd_q, rd_d;
  logic [WIDTH-1:0] rs_data, rt_data;
  alu_seq_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .RAW(RAW)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .we_i      (state_q == WB),
    .waddr_i   (rd_q),
    .wdata_i   (result_q),
    .raddr_a_i (bus.instr_rs),
    .raddr_b_i (bus.instr_rt),
    .raddr_d_i (bus.dbg_addr),
    .rdata_a_o (rs_data),
    .rdata_b_o (rt_data),
    .rdata_d_o (bus.dbg_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      cin_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      cin_q    <= cin_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    cin_d    = cin_q;
    rd_d     = rd_q;
    result_d = result_q;
    carry_d  = carry_q;
    case (state_q)
      IDLE: if (bus.instr_valid) begin
        rd_d = bus.instr_rd;
        if (bus.instr_ld) begin
          result_d = bus.instr_imm;
          state_d  = WB;
        end else begin
          a_d     = rs_data;
          b_d     = rt_data;
          s_d     = bus.instr_op;
          cin_d   = bus.instr_usec & carry_q;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = bus.alu_out;
        // co is only meaningful for add/subtract; other ops keep the flag
        carry_d  = (s_q == OP_ADD || s_q == OP_SUB) ? bus.alu_co : carry_q;
        state_d  = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.instr_ready = state_q == IDLE;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_s       = s_q;
  assign bus.alu_cin     = cin_q;
  assign bus.res_valid   = state_q == WB;
  assign bus.res_data    = result_q;
  assign bus.res_rd      = rd_q;
  assign bus.carry       = carry_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_q;
  always_ff @(posedge clk) begin
    if (rst) zero_q <= 1'b0;
    else if (state_q == WB) zero_q <= result_q == '0;
  end
  assign bus.zero = zero_q;
`endif
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed-vector bench for alu_seq_ctrl with a behavioural 4-bit ALU attached.
module tb_alu_seq_ctrl;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nmis = 0;
  int   acc_cnt = 0;
  logic bp_on = 1'b0;
  alu_seq_ctrl_if bus ();
  alu_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [4:0] alu_f(input logic [3:0] a, b, input logic cin, input logic [2:0] s);
    case (s)
      OP_ADD:  return {1'b0, a} + {1'b0, b} + {4'b0, cin};
      OP_SUB:  return {1'b0, a} - {1'b0, b} - {4'b0, cin};
      OP_OR:   return {1'b0, a | b};
      OP_AND:  return {1'b0, a & b};
      OP_SHL:  return {1'b0, a[2:0], 1'b0};
      OP_SHR:  return {2'b0, a[3:1]};
      OP_ROL:  return {1'b0, a[2:0], a[3]};
      default: return {1'b0, a[0], a[3:1]};
    endcase
  endfunction
  assign {bus.alu_co, bus.alu_out} = alu_f(bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_s);

  always @(posedge clk) if (bp_on && bus.instr_valid && bus.instr_ready) acc_cnt <= acc_cnt + 1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [1:0] rd, rs, rt, input logic usec, ld, input logic [3:0] imm);
    bus.instr_op   = op;
    bus.instr_rd   = rd;
    bus.instr_rs   = rs;
    bus.instr_rt   = rt;
    bus.instr_usec = usec;
    bus.instr_ld   = ld;
    bus.instr_imm  = imm;
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input logic [1:0] rd, rs, rt, input logic usec, ld, input logic [3:0] imm);
    int k = 0;
    @(negedge clk);
    set_instr(op, rd, rs, rt, usec, ld, imm);
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (k == 8) chk({tag, "_accept_timeout"}, 8'(bus.instr_ready), 8'd1);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
  endtask

  task automatic load(input logic [1:0] rd, input logic [3:0] imm);
    issue("ld", OP_ADD, rd, 2'd0, 2'd0, 1'b0, 1'b1, imm);
    @(negedge clk);
    chk("ld_res_valid", 8'(bus.res_valid), 8'd1);
    chk("ld_res_data", 8'(bus.res_data), 8'(imm));
    chk("ld_res_rd", 8'(bus.res_rd), 8'(rd));
    @(negedge clk);
    chk("ld_res_valid_drop", 8'(bus.res_valid), 8'd0);
  endtask

  task automatic alu_op(input string tag, input logic [2:0] op, input logic [1:0] rd, rs, rt, input logic usec,
                        input logic [3:0] exp_data, input logic exp_carry);
    issue(tag, op, rd, rs, rt, usec, 1'b0, 4'h0);
    @(negedge clk);
    chk({tag, "_exec_valid"}, 8'(bus.res_valid), 8'd0);
    chk({tag, "_exec_ready"}, 8'(bus.instr_ready), 8'd0);
    chk({tag, "_alu_s"}, 8'(bus.alu_s), 8'(op));
    @(negedge clk);
    chk({tag, "_wb_valid"}, 8'(bus.res_valid), 8'd1);
    chk({tag, "_wb_data"}, 8'(bus.res_data), 8'(exp_data));
    chk({tag, "_wb_rd"}, 8'(bus.res_rd), 8'(rd));
    @(negedge clk);
    bus.dbg_addr = rd;
    #1;
    chk({tag, "_carry"}, 8'(bus.carry), 8'(exp_carry));
    chk({tag, "_rf"}, 8'(bus.dbg_data), 8'(exp_data));
    chk({tag, "_valid_drop"}, 8'(bus.res_valid), 8'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk({tag, "_zero"}, 8'(bus.zero), 8'(exp_data == 4'h0));
`endif
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.dbg_addr = 2'd0;
    set_instr(3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 8'(bus.instr_ready), 8'd1);
    chk("rst_res_valid", 8'(bus.res_valid), 8'd0);
    chk("rst_res_data", 8'(bus.res_data), 8'd0);
    chk("rst_carry", 8'(bus.carry), 8'd0);
    chk("rst_alu", {bus.alu_a, bus.alu_b}, 8'h00);
    chk("rst_alu_s_cin", {4'h0, bus.alu_s, bus.alu_cin}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      bus.dbg_addr = 2'(i);
      #1 chk("rst_rf", 8'(bus.dbg_data), 8'h00);
    end
    // load and add, including no-bypass on the debug port during WB
    load(2'd1, 4'h5);
    load(2'd2, 4'h3);
    issue("add1", OP_ADD, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 4'h0);
    bus.dbg_addr = 2'd0;
    @(negedge clk);
    chk("add1_operands", {bus.alu_a, bus.alu_b}, 8'h53);
    chk("add1_exec_valid", 8'(bus.res_valid), 8'd0);
    @(negedge clk);
    chk("add1_wb_valid", 8'(bus.res_valid), 8'd1);
    chk("add1_wb_data", 8'(bus.res_data), 8'h08);
    chk("add1_dbg_nobypass", 8'(bus.dbg_data), 8'h00);
    @(negedge clk);
    chk("add1_rf", 8'(bus.dbg_data), 8'h08);
    chk("add1_carry", 8'(bus.carry), 8'd0);
    // chained add through the carry flag
    load(2'd1, 4'hF);
    load(2'd2, 4'h1);
    load(2'd0, 4'h0);
    alu_op("chain_lo", OP_ADD, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 1'b1);
    alu_op("chain_hi", OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 4'h1, 1'b0);
    // subtract with borrow
    load(2'd1, 4'h3);
    load(2'd2, 4'h5);
    alu_op("sub", OP_SUB, 2'd3, 2'd1, 2'd2, 1'b0, 4'hE, 1'b1);
    // logic op keeps the carry
    load(2'd1, 4'hF);
    load(2'd2, 4'h1);
    alu_op("carry_set", OP_ADD, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0, 1'b1);
    load(2'd1, 4'h9);
    alu_op("rol", OP_ROL, 2'd0, 2'd1, 2'd1, 1'b0, 4'h3, 1'b1);
    alu_op("shr", OP_SHR, 2'd2, 2'd1, 2'd1, 1'b1, 4'h4, 1'b1);
    // back-pressure: valid held high across two ALU instructions
    bp_on = 1'b1;
    @(negedge clk);
    set_instr(OP_ADD, 2'd2, 2'd1, 2'd1, 1'b0, 1'b0, 4'h0);
    bus.instr_valid = 1'b1;
    chk("bp_idle_ready", 8'(bus.instr_ready), 8'd1);
    @(negedge clk);
    chk("bp_exec_ready", 8'(bus.instr_ready), 8'd0);
    set_instr(OP_ADD, 2'd3, 2'd2, 2'd2, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    chk("bp_wb_ready", 8'(bus.instr_ready), 8'd0);
    chk("bp_a_data", 8'(bus.res_data), 8'h02);
    chk("bp_a_valid", 8'(bus.res_valid), 8'd1);
    @(negedge clk);
    chk("bp_idle2_ready", 8'(bus.instr_ready), 8'd1);
    chk("bp_accepts_mid", 8'(acc_cnt), 8'd1);
    @(negedge clk);
    chk("bp_exec2_ready", 8'(bus.instr_ready), 8'd0);
    @(negedge clk);
    chk("bp_b_data", 8'(bus.res_data), 8'h04);
    chk("bp_b_valid", 8'(bus.res_valid), 8'd1);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    bp_on = 1'b0;
    bus.dbg_addr = 2'd2;
    #1 chk("bp_rf_r2", 8'(bus.dbg_data), 8'h02);
    bus.dbg_addr = 2'd3;
    #1 chk("bp_rf_r3", 8'(bus.dbg_data), 8'h04);
    chk("bp_accepts", 8'(acc_cnt), 8'd2);
    chk("bp_carry", 8'(bus.carry), 8'd0);
    // reset in the middle of EXEC
    load(2'd2, 4'h7);
    issue("rst_mid", OP_ADD, 2'd2, 2'd1, 2'd1, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    chk("rstmid_in_exec", 8'(bus.instr_ready), 8'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_valid0", 8'(bus.res_valid), 8'd0);
    @(negedge clk);
    bus.dbg_addr = 2'd2;
    #1;
    chk("rstmid_valid1", 8'(bus.res_valid), 8'd0);
    chk("rstmid_ready", 8'(bus.instr_ready), 8'd1);
    chk("rstmid_rf_r2", 8'(bus.dbg_data), 8'h00);
    chk("rstmid_carry", 8'(bus.carry), 8'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("rstmid_zero", 8'(bus.zero), 8'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing stage directly upstream of the 4-bit combinational ALU. It accepts one instruction at a time over a valid/ready handshake and reads operands from a small register file. It drives the ALU's a/b/cin/s inputs from registers, captures the ALU's out/co back into the register file and a carry flag, and reports each result with a one-cycle pulse. The stored carry enables chained multi-nibble add/subtract.

Parameters:
WIDTH, 4, datapath width; must equal the ALU operand width
NREGS, 4, register file depth
RAW, 2, register address width, equal to log2(NREGS)

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instruction present
instr_ready  out  1  block can accept an instruction
instr_op  in  3  ALU select code, same encoding as the ALU's s input
instr_rd  in  RAW  destination register
instr_rs  in  RAW  operand A register
instr_rt  in  RAW  operand B register
instr_usec  in  1  1 = cin comes from the carry flag; 0 = cin is 0
instr_ld  in  1  1 = load instr_imm into rd; the ALU is not used
instr_imm  in  WIDTH  load immediate
alu_a  out  WIDTH  registered operand A to the ALU
alu_b  out  WIDTH  registered operand B to the ALU
alu_cin  out  1  registered carry-in to the ALU
alu_s  out  3  registered op select to the ALU
alu_out  in  WIDTH  ALU result
alu_co  in  1  ALU carry/borrow out
res_valid  out  1  one-cycle pulse when a result is written back
res_data  out  WIDTH  value written back
res_rd  out  RAW  register written
carry  out  1  current carry flag
dbg_addr  in  RAW  debug read address
dbg_data  out  WIDTH  combinational read of rf[dbg_addr]

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all rf entries 0, carry 0, alu_a/alu_b/alu_s/alu_cin 0, res_valid 0, res_data 0, res_rd 0, state IDLE.
- States: IDLE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready with instr_ld=0: latch alu_a=rf[rs], alu_b=rf[rt], alu_s=op, alu_cin=usec?carry:0, and rd. Go to EXEC.
  - On a handshake with instr_ld=1: latch imm and rd. Go to WB.
- EXEC:
  - instr_ready=0.
  - The ALU settles combinationally.
  - At the end of the cycle, capture alu_out into a result register.
  - For op 000/001, also capture alu_co as the new carry; for ops 010-111, carry is held because the ALU's co is undefined for them.
  - Go to WB.
- WB:
  - instr_ready=0.
  - res_valid=1, res_data=result, res_rd=rd.
  - rf[rd] is written at the end of the cycle. Go to IDLE.
  - res_valid deasserts in the next cycle.
- Latency: handshake at edge t gives res_valid high during cycle t+2 (ALU op) or t+1 (load).
  - Throughput: one ALU op per 3 cycles, one load per 2 cycles.
- Subtract carry: the value captured is bit 4 of a-b-cin, i.e. 1 = borrow.
- Register aliasing: rs, rt and rd may alias. Operands are read at acceptance, so there is no hazard.
- instr_valid while busy: the instruction is not accepted and must be held by the sender.
- dbg_data: reflects rf contents including a write in the same cycle only after the clock edge (no bypass).
- Reset mid-operation (EXEC or WB): the instruction is aborted, no rf or carry write occurs, and res_valid stays 0 from the next cycle.

Optional Feature:
ALU_SEQ_ZERO_FLAG_EN
- Defined: adds output port zero (1 bit, reset 0). zero is updated at WB to (res_data==0) for both ALU ops and loads, and held otherwise.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode constants: OP_ADD=000, OP_SUB=001, OP_OR=010, OP_AND=011, OP_SHL=100, OP_SHR=101, OP_ROL=110, OP_ROR=111.
  - The WIDTH default.
  - The state enum typedef.
- One natural sub-module, alu_seq_regfile: NREGS x WIDTH, two read ports for rs/rt, one debug read port, one synchronous write port, and synchronous clear on rst.
- The ALU itself stays external.

Test Plan:
- Load and add: LD r1=5, LD r2=3, then ADD rd=r0,rs=r1,rt=r2,usec=0 -> res_valid in cycle t+2, res_data=8, carry=0, dbg r0=8.
- Chained add: LD r1=F, LD r2=1, ADD r3=r1+r2 usec=0 -> res_data=0, carry=1. Then ADD r0=r0+r0 with r0=0, usec=1 -> res_data=1, carry=0.
- Subtract with borrow: r1=3, r2=5, SUB usec=0 -> res_data=E, carry=1.
- Logic op holds carry: set carry=1 via the chained add, then ROL on r=9 -> res_data=3 and carry still 1.
- Back-pressure: hold instr_valid high continuously -> instr_ready low in EXEC/WB, exactly one accept per 3 cycles, no instruction dropped or duplicated.
- Reset mid-EXEC: assert rst during EXEC of ADD into r2 (previously 7) -> r2=0 after reset, res_valid never pulses, state IDLE, instr_ready=1 after rst deasserts.
